// File: rtl/operand_entry_fsm.sv
// Operand-entry stage: synchronizes and debounces one button, then captures A, B and ctrl
// from the switches on successive presses. Optional long-press clear: define LONG_PRESS_CLEAR_EN.
module operand_entry_fsm #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Sw,
  input  logic             Btn,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ctrl,
  output logic             Valid,
  output logic [1:0]       Stage
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("operand_entry_fsm: DEBOUNCE_CYCLES and LONG_CYCLES must be at least 2");
  end

  logic             btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [WIDTH-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic             deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ctrl_q, ctrl_d;
  logic             valid_q, valid_d;
  logic             press;

`ifdef LONG_PRESS_CLEAR_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves a latch behind.
    btn_s1_d   = Btn;
    btn_s2_d   = btn_s1_q;
    sw_s1_d    = Sw;
    sw_s2_d    = sw_s1_q;
    deb_d      = deb_q;
    db_cnt_d   = '0;
    deb_prev_d = deb_q;
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    valid_d    = valid_q;

    if (btn_s2_q != deb_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    // Pulse in the cycle after the debounced level rises; release is ignored.
    press = deb_q & ~deb_prev_q;

    if (press) begin
      unique case (state_q)
        S_A:    begin a_d = sw_s2_q; state_d = S_B; end
        S_B:    begin b_d = sw_s2_q; state_d = S_OP; end
        S_OP:   begin ctrl_d = sw_s2_q; valid_d = 1'b1; state_d = S_SHOW; end
        S_SHOW: begin valid_d = 1'b0; state_d = S_A; end
        default: state_d = S_A;
      endcase
    end

`ifdef LONG_PRESS_CLEAR_EN
    // Counter saturates at LONG_CYCLES, so the clear fires exactly once per hold.
    hold_cnt_d = '0;
    if (deb_q) begin
      hold_cnt_d = hold_cnt_q;
      if (hold_cnt_q != HOLD_W'(LONG_CYCLES)) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      if (hold_cnt_q == HOLD_W'(LONG_CYCLES - 1)) begin
        a_d     = '0;
        b_d     = '0;
        ctrl_d  = '0;
        valid_d = 1'b0;
        state_d = S_A;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset wins over any press.
    if (rst) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      valid_q    <= 1'b0;
`ifdef LONG_PRESS_CLEAR_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
`ifdef LONG_PRESS_CLEAR_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign ctrl  = ctrl_q;
  assign Valid = valid_q;
  assign Stage = state_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Self-checking bench for operand_entry_fsm: table-driven entry sequence with a
// scoreboard queue, plus hand-written bounce, reset and long-hold sequences.
module tb_operand_entry_fsm;

  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] Sw;
  logic       Btn;
  logic [2:0] A, B, ctrl;
  logic       Valid;
  logic [1:0] Stage;

  operand_entry_fsm #(
    .WIDTH(3), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk), .rst(rst), .Sw(Sw), .Btn(Btn),
    .A(A), .B(B), .ctrl(ctrl), .Valid(Valid), .Stage(Stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] c;
    logic       v;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    logic [2:0] sw;
    exp_t       exp;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  vec_t vecs[8];

  function automatic exp_t mk_exp(input logic [2:0] a, b, c, input logic v, input logic [1:0] st);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.v = v; e.st = st;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic [2:0] sw, input exp_t e);
    vec_t r;
    r.sw = sw; r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input exp_t e);
    check({name, "_A"}, 32'(A), 32'(e.a));
    check({name, "_B"}, 32'(B), 32'(e.b));
    check({name, "_ctrl"}, 32'(ctrl), 32'(e.c));
    check({name, "_Valid"}, 32'(Valid), 32'(e.v));
    check({name, "_Stage"}, 32'(Stage), 32'(e.st));
  endtask

  // Drive one press; the expected result is queued now and popped when Stage moves.
  // lat = edges from the first edge that samples Btn high to the edge that updates Stage.
  task automatic press(input string name, input logic [2:0] sw, input int hold,
                       input exp_t e, output int lat);
    logic [1:0] st0;
    exp_t       got;
    Sw = sw;
    repeat (4) @(negedge clk);
    st0 = Stage;
    sb.push_back(e);
    Btn = 1'b1;
    lat = -1;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (lat < 0 && Stage != st0) begin
        lat = k - 1;
        got = sb.pop_front();
        check_outputs(name, got);
      end
    end
    Btn = 1'b0;
    if (lat < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: Stage stayed %0d, expected a change within %0d cycles", name, st0, hold);
      void'(sb.pop_front());
    end
    repeat (DEB + 4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  seen;

    vecs[0] = mk_vec(3'd5, mk_exp(3'd5, 3'd0, 3'd0, 1'b0, 2'd1));
    vecs[1] = mk_vec(3'd3, mk_exp(3'd5, 3'd3, 3'd0, 1'b0, 2'd2));
    vecs[2] = mk_vec(3'd2, mk_exp(3'd5, 3'd3, 3'd2, 1'b1, 2'd3));
    vecs[3] = mk_vec(3'd7, mk_exp(3'd5, 3'd3, 3'd2, 1'b0, 2'd0));
    vecs[4] = mk_vec(3'd7, mk_exp(3'd7, 3'd3, 3'd2, 1'b0, 2'd1));
    vecs[5] = mk_vec(3'd6, mk_exp(3'd7, 3'd6, 3'd2, 1'b0, 2'd2));
    vecs[6] = mk_vec(3'd5, mk_exp(3'd7, 3'd6, 3'd5, 1'b1, 2'd3));
    vecs[7] = mk_vec(3'd0, mk_exp(3'd7, 3'd6, 3'd5, 1'b0, 2'd0));

    // Reset with the button held: outputs must be zero on every edge under reset.
    rst = 1'b1; Btn = 1'b1; Sw = 3'd5;
    repeat (2) begin
      @(negedge clk);
      check_outputs("reset", mk_exp(3'd0, 3'd0, 3'd0, 1'b0, 2'd0));
    end
    Btn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Full entry, wrap, re-entry and verbatim ctrl=5.
    for (int i = 0; i < 8; i++) begin
      press($sformatf("vec%0d", i), vecs[i].sw, 8, vecs[i].exp, lat);
      if (i == 0) check("first_capture_latency", 32'(lat), 32'(DEB + 2));
    end

    // Bounce: two 3-cycle highs must be rejected, then one clean press advances once.
    Sw = 3'd4;
    repeat (4) @(negedge clk);
    repeat (2) begin
      Btn = 1'b1; repeat (3) @(negedge clk);
      Btn = 1'b0; repeat (3) @(negedge clk);
    end
    repeat (DEB + 4) @(negedge clk);
    check("bounce_rejected_Stage", 32'(Stage), 32'd0);
    check("bounce_rejected_A", 32'(A), 32'd7);
    press("bounce_clean", 3'd4, 8, mk_exp(3'd4, 3'd6, 3'd5, 1'b0, 2'd1), lat);
    repeat (10) @(negedge clk);
    check("bounce_single_advance", 32'(Stage), 32'd1);

    // Reset in the same cycle as a press in S_B: reset wins, no B capture.
    do_reset();
    press("pre_midreset", 3'd6, 8, mk_exp(3'd6, 3'd0, 3'd0, 1'b0, 2'd1), lat);
    Sw = 3'd1;
    repeat (4) @(negedge clk);
    Btn = 1'b1;
    repeat (DEB + 2) @(negedge clk);
    check("midreset_before_Stage", 32'(Stage), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_outputs("midreset", mk_exp(3'd0, 3'd0, 3'd0, 1'b0, 2'd0));

    // Button still held as reset releases: accepted as a press after the debounce time.
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (Stage != 2'd0) seen = 1'b1;
    end
    check("held_through_reset_seen", 32'(seen), 32'd1);
    check_outputs("held_through_reset", mk_exp(3'd1, 3'd0, 3'd0, 1'b0, 2'd1));
    Btn = 1'b0;
    repeat (DEB + 4) @(negedge clk);

    // Long hold from S_SHOW: wrap on press, then clear only when the feature is built.
    do_reset();
    press("long_e0", 3'd5, 8, mk_exp(3'd5, 3'd0, 3'd0, 1'b0, 2'd1), lat);
    press("long_e1", 3'd3, 8, mk_exp(3'd5, 3'd3, 3'd0, 1'b0, 2'd2), lat);
    press("long_e2", 3'd2, 8, mk_exp(3'd5, 3'd3, 3'd2, 1'b1, 2'd3), lat);
    press("long_hold", 3'd6, 40, mk_exp(3'd5, 3'd3, 3'd2, 1'b0, 2'd0), lat);
`ifdef LONG_PRESS_CLEAR_EN
    check_outputs("long_cleared", mk_exp(3'd0, 3'd0, 3'd0, 1'b0, 2'd0));
    repeat (20) @(negedge clk);
    check_outputs("long_after_release", mk_exp(3'd0, 3'd0, 3'd0, 1'b0, 2'd0));
`else
    check_outputs("long_no_clear", mk_exp(3'd5, 3'd3, 3'd2, 1'b0, 2'd0));
    repeat (20) @(negedge clk);
    check_outputs("long_after_release", mk_exp(3'd5, 3'd3, 3'd2, 1'b0, 2'd0));
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global guard so the run always ends by itself.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation ran past its time budget");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/operand_entry_fsm.md
Name: operand_entry_fsm

Overview:
- Upstream operand-entry stage for the arithmetic/LED selector.
- Turns one push button and the 3 slide switches into registered A, B and ctrl, entered one after another.
- Debounces the button and steps through an entry state machine.
- Holds the captured values stable, with a Valid flag, for the downstream arithmetic/select stage.

Parameters:
- WIDTH, 3, width of operands A, B and of ctrl (all come from the same switch bank).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level change (use 4 in simulation).
- LONG_CYCLES, 50000000, debounced hold time for long-press clear; used only with the optional feature (use 16 in simulation).

Ports:
- clk  input  1  system clock, all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- Sw  input  WIDTH  slide switches, quasi-static, asynchronous to clk
- Btn  input  1  entry push button, asynchronous and bouncy, high = pressed
- A  output  WIDTH  captured operand A, registered
- B  output  WIDTH  captured operand B, registered
- ctrl  output  WIDTH  captured operation select, registered
- Valid  output  1  high while A, B and ctrl form a complete, consistent set
- Stage  output  2  current entry state code, for status LEDs

Behaviour:
- Reset (synchronous, active-high) sets:
  - A=0, B=0, ctrl=0, Valid=0, Stage=00
  - both synchronizer flops to 0, debounced level to 0, debounce counter to 0
- Reset has priority over every other event, including a press in the same cycle.
- Synchronizers: Btn and Sw each pass through a 2-flop synchronizer. Only the synchronized Sw is ever captured.
- Debounce:
  - The counter increments each cycle the synchronized button differs from the debounced level.
  - The counter clears on any cycle they are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never toggles the debounced level.
- Press event: a one-cycle pulse on the cycle after the debounced level rises. Only a rising edge counts; release does nothing.
- Timing: if Btn is first sampled high at edge N and stays high, the captured register updates at edge N+DEBOUNCE_CYCLES+2.
- FSM (Stage code in brackets):
  - S_A (00): on press, A<=Sw, go to S_B.
  - S_B (01): on press, B<=Sw, go to S_OP.
  - S_OP (10): on press, ctrl<=Sw, Valid<=1, go to S_SHOW.
  - S_SHOW (11): on press, Valid<=0, go to S_A. A, B and ctrl keep their old values until overwritten.
  - Without a press, state and all outputs hold.
- ctrl is captured verbatim, including 5..7; the downstream stage maps those to 0.
- Valid rises on the same edge that ctrl is written, and is low in S_A, S_B and S_OP.
- Button held through reset release: the debounced level starts at 0, so the hold is accepted as a press after the debounce time. A is then captured from Sw.
- Sw changing in the press cycle: the synchronized value present at the capture edge is taken.

Optional Feature:
- Macro: LONG_PRESS_CLEAR_EN
- Defined:
  - A hold counter runs while the debounced level is high and clears when it is low.
  - When the counter reaches LONG_CYCLES-1, in the next cycle A, B and ctrl are set to 0, Valid to 0 and state to S_A.
  - This fires once per hold; the counter saturates until release.
  - The normal press-edge action at the start of the hold has already taken effect; the clear overrides it.
- Not defined: no hold counter is built, and hold duration has no effect beyond the single press.

Test Plan:
- Reset: rst=1 for 2 cycles with Btn=1 -> A=B=ctrl=0, Valid=0, Stage=00 on every edge while rst is high.
- Full entry (DEBOUNCE_CYCLES=4): Sw=5 then press, Sw=3 then press, Sw=2 then press.
  - Required: A=5, B=3, ctrl=2, Valid=1, Stage=11.
  - The first update lands exactly 6 edges after Btn is first sampled high.
- Bounce rejection: Btn pulses 1-0-1-0 with 3-cycle highs, then a clean 8-cycle high.
  - Required: exactly one state advance; Stage goes 00->01 only.
- Wrap: in S_SHOW, press with Sw=7.
  - Required: Valid=0, Stage=00, A/B/ctrl unchanged at 5/3/2.
  - Then a press with Sw=7 gives A=7.
- Reset mid-entry: in S_B with A=6, assert rst in the same cycle as a press.
  - Required: A=0, Stage=00, no capture of B.
- LONG_PRESS_CLEAR_EN, LONG_CYCLES=16: after full entry, hold Btn for 40 cycles.
  - Required: press returns Stage to 00, then after 16 debounced-high cycles A=B=ctrl=0.
  - Required: release causes no further change.
